// File: rtl/eq_gain_sequencer_pkg.sv
// Shared encodings for the equalizer gain sequencer: command ops, band
// selector for "all bands" and the sequencer FSM states.
package eq_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET     = 2'b00,
    OP_INC     = 2'b01,
    OP_DEC     = 2'b10,
    OP_DEFAULT = 2'b11
  } op_e;

  localparam logic [1:0] BAND_ALL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_RAMP      = 2'd2
  } state_e;

endpackage

// File: rtl/eq_gain_sequencer_if.sv
// Gain command channel from the PS/2 front end (valid/ready handshake).
// The source holds every field stable while cmd_valid is high and cmd_ready low.
interface eq_gain_sequencer_if #(
  parameter int GW = 2
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_band;
  logic [1:0]    cmd_op;
  logic [GW-1:0] cmd_value;

  modport master (
    output cmd_valid, cmd_band, cmd_op, cmd_value,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_band, cmd_op, cmd_value,
    output cmd_ready
  );
endinterface

// File: rtl/eq_gain_sequencer_gain_step.sv
// Per-band target/committed gain pair. Applies a saturating command to the
// target and, on commit, moves the committed gain toward the target.
// GAIN_RAMP_EN: when defined, each commit moves the gain by one LSB;
// otherwise the commit copies the target in one step.
module gain_step
  import eq_ctrl_pkg::*;
#(
  parameter int            GW           = 2,
  parameter logic [GW-1:0] GAIN_DEFAULT = 2'd1,
  parameter logic [GW-1:0] GAIN_MAX     = 2'd3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  op_e           op,
  input  logic [GW-1:0] value,
  input  logic          commit,
  output logic [GW-1:0] target,
  output logic [GW-1:0] gain,
  output logic          changed,
  output logic          settled
);

  logic [GW:0]   ext_target;
  logic [GW:0]   ext_value;
  logic [GW:0]   ext_max;
  logic [GW:0]   sum;
  logic [GW:0]   diff;
  logic [GW-1:0] target_nxt;
  logic [GW-1:0] commit_val;

  // Saturating target arithmetic, one bit wider than the gain word.
  always_comb begin
    ext_target = {1'b0, target};
    ext_value  = {1'b0, value};
    ext_max    = {1'b0, GAIN_MAX};
    sum        = ext_target + 1'b1;
    diff       = ext_target - 1'b1;
    target_nxt = target;
    case (op)
      OP_SET:     target_nxt = (ext_value > ext_max) ? GAIN_MAX : value;
      OP_INC:     target_nxt = (sum > ext_max) ? GAIN_MAX : sum[GW-1:0];
      OP_DEC:     target_nxt = (ext_target == '0) ? '0 : diff[GW-1:0];
      OP_DEFAULT: target_nxt = GAIN_DEFAULT;
      default:    target_nxt = target;
    endcase
  end

  // Value the gain takes on the next commit.
  always_comb begin
`ifdef GAIN_RAMP_EN
    if (gain < target)      commit_val = gain + 1'b1;
    else if (gain > target) commit_val = gain - 1'b1;
    else                    commit_val = gain;
`else
    commit_val = target;
`endif
    changed = (commit_val != gain);
    settled = (commit_val == target);
  end

  // Target follows accepted commands; gain only moves on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= GAIN_DEFAULT;
      gain   <= GAIN_DEFAULT;
    end else begin
      if (load)   target <= target_nxt;
      if (commit) gain   <= commit_val;
    end
  end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Equalizer gain sequencer: accepts gain commands, saturates them into
// per-band targets and commits targets to the datapath gains only on ADC
// sample boundaries (the clk after a sample_tick).
// GAIN_RAMP_EN: when defined, gains step one LSB per tick through RAMP.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | ready for a command, gains equal targets
// ST_WAIT_TICK | command applied to targets, waiting for sample_tick
// ST_RAMP      | gains stepping toward targets, one step per tick
module eq_gain_sequencer
  import eq_ctrl_pkg::*;
#(
  parameter int            GW           = 2,
  parameter logic [GW-1:0] GAIN_DEFAULT = 2'd1,
  parameter logic [GW-1:0] GAIN_MAX     = 2'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  eq_gain_sequencer_if.slave   cmd,
  input  logic                 sample_tick,
  output logic [GW-1:0]        gain1,
  output logic [GW-1:0]        gain2,
  output logic [GW-1:0]        gain3,
  output logic                 update_pulse,
  output logic                 busy
);

  state_e        state, state_nxt;
  logic          ready;
  logic          commit;
  logic          transfer;
  logic [2:0]    load;
  logic [2:0]    changed;
  logic [2:0]    settled;
  logic [2:0]    mismatch;
  logic [GW-1:0] target [3];
  logic [GW-1:0] gain   [3];

  assign cmd.cmd_ready = ready;
  assign transfer      = cmd.cmd_valid & ready;

  // Band decode: BAND_ALL hits every band, otherwise only the addressed one.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      load[i] = transfer & ((cmd.cmd_band == BAND_ALL) || (cmd.cmd_band == 2'(i)));
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_band
    gain_step #(
      .GW           (GW),
      .GAIN_DEFAULT (GAIN_DEFAULT),
      .GAIN_MAX     (GAIN_MAX)
    ) u_step (
      .clk     (clk),
      .rst     (rst),
      .load    (load[g]),
      .op      (op_e'(cmd.cmd_op)),
      .value   (cmd.cmd_value),
      .commit  (commit),
      .target  (target[g]),
      .gain    (gain[g]),
      .changed (changed[g]),
      .settled (settled[g])
    );
    assign mismatch[g] = (target[g] != gain[g]);
  end

  assign gain1 = gain[0];
  assign gain2 = gain[1];
  assign gain3 = gain[2];
  assign busy  = (state != ST_IDLE) | (|mismatch);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake ready and commit strobe. A tick coinciding with
  // the transfer is seen in IDLE and therefore ignored.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) state_nxt = ST_WAIT_TICK;
      end
      ST_WAIT_TICK, ST_RAMP: begin
        if (sample_tick) begin
          commit    = 1'b1;
          state_nxt = (&settled) ? ST_IDLE : ST_RAMP;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pulse in the same cycle the committed gains become visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) update_pulse <= 1'b0;
    else     update_pulse <= commit & (|changed);
  end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
module tb_eq_gain_sequencer;
  import eq_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic [1:0] gain1, gain2, gain3;
  logic       update_pulse, busy;
  int         n_checks = 0;
  int         n_fail = 0;
  int         pulse_cnt = 0;

  eq_gain_sequencer_if #(.GW(2)) bus ();

  eq_gain_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (bus),
    .sample_tick  (sample_tick),
    .gain1        (gain1),
    .gain2        (gain2),
    .gain3        (gain3),
    .update_pulse (update_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update_pulse) pulse_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command and hold it until accepted; returns at the negedge after transfer.
  task automatic send(input logic [1:0] band, input op_e op, input logic [1:0] value);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_band  = band;
    bus.cmd_op    = op;
    bus.cmd_value = value;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // One-clk sample_tick; returns at the negedge after the commit edge.
  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++; if (gain1 !== 2'd1) begin n_fail++; $display("FAIL reset_gain1: got %0d expected 1", gain1); end
    n_checks++; if (gain2 !== 2'd1) begin n_fail++; $display("FAIL reset_gain2: got %0d expected 1", gain2); end
    n_checks++; if (gain3 !== 2'd1) begin n_fail++; $display("FAIL reset_gain3: got %0d expected 1", gain3); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", bus.cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0b expected 0", update_pulse); end
  endtask

  task automatic test_set_late_tick();
    send(2'd0, OP_SET, 2'd3);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL set_ready_wait: got %0b expected 0", bus.cmd_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL set_busy_wait: got %0b expected 1", busy); end
    cycles(20);
    n_checks++; if (gain1 !== 2'd1) begin n_fail++; $display("FAIL set_gain1_hold: got %0d expected 1", gain1); end
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL set_pulse_hold: got %0b expected 0", update_pulse); end
    tick();
`ifdef GAIN_RAMP_EN
    n_checks++; if (gain1 !== 2'd2) begin n_fail++; $display("FAIL set_gain1_step: got %0d expected 2", gain1); end
    n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL set_pulse_step: got %0b expected 1", update_pulse); end
    tick();
`endif
    n_checks++; if (gain1 !== 2'd3) begin n_fail++; $display("FAIL set_gain1_commit: got %0d expected 3", gain1); end
    n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL set_pulse_commit: got %0b expected 1", update_pulse); end
    cycles(1);
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL set_pulse_one_clk: got %0b expected 0", update_pulse); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL set_ready_idle: got %0b expected 1", bus.cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL set_busy_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_band3_ramp();
    send(2'd2, OP_SET, 2'd0);
    tick();
    n_checks++; if (gain3 !== 2'd0) begin n_fail++; $display("FAIL b3_gain3_to0: got %0d expected 0", gain3); end
    n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL b3_pulse_to0: got %0b expected 1", update_pulse); end
    cycles(1);
    send(2'd2, OP_SET, 2'd3);
`ifdef GAIN_RAMP_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (gain3 !== 2'(k)) begin n_fail++; $display("FAIL b3_ramp_up: got %0d expected %0d", gain3, k); end
    end
`else
    tick();
    n_checks++; if (gain3 !== 2'd3) begin n_fail++; $display("FAIL b3_gain3_to3: got %0d expected 3", gain3); end
`endif
    cycles(1);
    send(2'd2, OP_SET, 2'd0);
`ifdef GAIN_RAMP_EN
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (gain3 !== 2'(3 - k)) begin n_fail++; $display("FAIL b3_ramp_down: got %0d expected %0d", gain3, 3 - k); end
      n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL b3_ramp_pulse: got %0b expected 1", update_pulse); end
      if (k < 3) begin
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b3_ramp_ready: got %0b expected 0", bus.cmd_ready); end
      end
    end
`else
    tick();
    n_checks++; if (gain3 !== 2'd0) begin n_fail++; $display("FAIL b3_gain3_3to0: got %0d expected 0", gain3); end
`endif
    cycles(1);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b3_ready_idle: got %0b expected 1", bus.cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b3_busy_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_inc_saturate();
    int p0 = pulse_cnt;
    for (int k = 0; k < 2; k++) begin
      send(2'd0, OP_INC, 2'd0);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL inc_busy_wait: got %0b expected 1", busy); end
      tick();
      n_checks++; if (gain1 !== 2'd3) begin n_fail++; $display("FAIL inc_gain1_sat: got %0d expected 3", gain1); end
      n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL inc_no_pulse: got %0b expected 0", update_pulse); end
      cycles(1);
      n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL inc_ready_idle: got %0b expected 1", bus.cmd_ready); end
    end
    n_checks++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL inc_pulse_count: got %0d expected %0d", pulse_cnt, p0); end
  endtask

  task automatic test_same_cycle_tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_band  = 2'd1;
    bus.cmd_op    = OP_SET;
    bus.cmd_value = 2'd2;
    sample_tick   = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    sample_tick   = 1'b0;
    n_checks++; if (gain2 !== 2'd1) begin n_fail++; $display("FAIL same_gain2_nocommit: got %0d expected 1", gain2); end
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL same_no_pulse: got %0b expected 0", update_pulse); end
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL same_ready_wait: got %0b expected 0", bus.cmd_ready); end
    cycles(3);
    n_checks++; if (gain2 !== 2'd1) begin n_fail++; $display("FAIL same_gain2_hold: got %0d expected 1", gain2); end
    tick();
    n_checks++; if (gain2 !== 2'd2) begin n_fail++; $display("FAIL same_gain2_commit: got %0d expected 2", gain2); end
    n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL same_pulse_commit: got %0b expected 1", update_pulse); end
    cycles(1);
  endtask

  task automatic test_back_to_back();
    bus.cmd_valid = 1'b1;
    bus.cmd_band  = 2'd1;
    bus.cmd_op    = OP_INC;
    bus.cmd_value = 2'd0;
    @(negedge clk);
    bus.cmd_op = OP_DEC;
    cycles(3);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_held: got %0b expected 0", bus.cmd_ready); end
    n_checks++; if (gain2 !== 2'd2) begin n_fail++; $display("FAIL b2b_gain2_before: got %0d expected 2", gain2); end
    tick();
    n_checks++; if (gain2 !== 2'd3) begin n_fail++; $display("FAIL b2b_gain2_first: got %0d expected 3", gain2); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_second: got %0b expected 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_second_taken: got ready=%0b expected 0", bus.cmd_ready); end
    tick();
    n_checks++; if (gain2 !== 2'd2) begin n_fail++; $display("FAIL b2b_gain2_second: got %0d expected 2", gain2); end
    cycles(4);
    n_checks++; if (gain2 !== 2'd2) begin n_fail++; $display("FAIL b2b_no_duplicate: got %0d expected 2", gain2); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_idle: got %0b expected 0", busy); end
  endtask

  task automatic test_all_default_reset();
    send(BAND_ALL, OP_DEFAULT, 2'd0);
    tick();
`ifdef GAIN_RAMP_EN
    n_checks++; if ({gain1, gain2, gain3} !== {2'd2, 2'd1, 2'd1}) begin n_fail++; $display("FAIL all_step1: got %0d,%0d,%0d expected 2,1,1", gain1, gain2, gain3); end
    tick();
`endif
    n_checks++; if ({gain1, gain2, gain3} !== {2'd1, 2'd1, 2'd1}) begin n_fail++; $display("FAIL all_default: got %0d,%0d,%0d expected 1,1,1", gain1, gain2, gain3); end
    n_checks++; if (update_pulse !== 1'b1) begin n_fail++; $display("FAIL all_pulse: got %0b expected 1", update_pulse); end
    cycles(1);
    send(2'd0, OP_SET, 2'd3);
`ifdef GAIN_RAMP_EN
    tick();
    n_checks++; if (gain1 !== 2'd2) begin n_fail++; $display("FAIL rst_pre_gain1: got %0d expected 2", gain1); end
`endif
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ready: got %0b expected 0", bus.cmd_ready); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({gain1, gain2, gain3} !== {2'd1, 2'd1, 2'd1}) begin n_fail++; $display("FAIL rst_gains: got %0d,%0d,%0d expected 1,1,1", gain1, gain2, gain3); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", bus.cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse: got %0b expected 0", update_pulse); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++; if (gain1 !== 2'd1) begin n_fail++; $display("FAIL rst_idle_tick_gain1: got %0d expected 1", gain1); end
    n_checks++; if (update_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_idle_tick_pulse: got %0b expected 0", update_pulse); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %0b expected 0", busy); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_band  = 2'd0;
    bus.cmd_op    = 2'd0;
    bus.cmd_value = 2'd0;
    test_reset();
    test_set_late_tick();
    test_band3_ramp();
    test_inc_saturate();
    test_same_cycle_tick();
    test_back_to_back();
    test_all_default_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
